bsg_zynq_pair_adder: RTL
========================

BSG_ZYNQ_PAIR_ADDER -- requirements
Module: bsg_zynq_pair_adder

Interface
REQ-001 Parameter width_p, default 32: operand and result width, equal to the AXI-lite data width.
REQ-002 Parameter count_width_p, default 32: width of the status counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 aclk  in  1  clock; all state changes on its rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 en_i  in  1  CSR enable; when low, no new operands are accepted and the output drains.
REQ-007 clear_i  in  1  single-cycle pulse that zeroes both counters.
REQ-008 a_data_i  in  width_p  operand A, from the ps-to-pl FIFO of port 0.
REQ-009 a_v_i  in  1  operand A valid.
REQ-010 a_yumi_o  out  1  operand A dequeue; asserted only when a_v_i=1.
REQ-011 b_data_i  in  width_p  operand B, from the ps-to-pl FIFO of port 1.
REQ-012 b_v_i  in  1  operand B valid.
REQ-013 b_yumi_o  out  1  operand B dequeue; asserted only when b_v_i=1.
REQ-014 data_o  out  width_p  sum, to a pl-to-ps FIFO.
REQ-015 v_o  out  1  sum valid.
REQ-016 ready_i  in  1  consumer ready; transfer when v_o&ready_i.
REQ-017 sum_count_o  out  count_width_p  number of sums produced.
REQ-018 ovf_count_o  out  count_width_p  number of sums that had a carry-out.

Function
REQ-019 The block SHALL hold one operand register and one full flag per side (A, B); the two sides operate independently.
REQ-020 fire = a_full & b_full & output-buffer-not-full.
REQ-021 a_yumi_o = en_i & a_v_i & (~a_full | fire); b_yumi_o is defined the same way with B signals. Each side SHALL refill in the same cycle it is consumed.
REQ-022 On fire, {carry, sum} = a_reg + b_reg, computed at width_p+1 bits; sum (modulo 2^width_p) enters the output buffer.
REQ-023 Latency from the first cycle both yumis have fired to v_o=1 SHALL be 2 cycles (capture, then compute/enqueue). Sustained throughput SHALL be 1 sum per cycle while ready_i=1.
REQ-024 The output buffer SHALL be 2 entries deep and FIFO-ordered; data_o and v_o SHALL come from registers.
REQ-025 When the buffer is full, fire=0 and the operand registers hold. No operand is dropped or duplicated.
REQ-026 A side that is full SHALL wait indefinitely for the other side; there is no timeout.
REQ-027 en_i=0 blocks new capture only. Already-captured operands still fire, and the buffer still drains.
REQ-028 sum_count increments on each fire; ovf_count increments on each fire with carry=1. Both wrap at 2^count_width_p.
REQ-029 If clear_i and fire occur in the same cycle, clear SHALL win: the counter becomes 0, not 1.
REQ-030 The handshake outputs SHALL have no combinational path from ready_i to a_yumi_o or b_yumi_o, other than through the registered buffer-full state.

Reset
REQ-031 While aresetn=0: both full flags, buffer occupancy and both counters SHALL be 0; v_o=0, a_yumi_o=0, b_yumi_o=0.
REQ-032 After reset, data_o is don't-care while v_o=0. Operand registers need no reset.
REQ-033 A reset asserted mid-operation SHALL discard captured operands and buffered sums immediately and asynchronously.

Structure
REQ-034 The output buffer SHALL be a sub-module, bsg_two_fifo (valid/ready in and valid/ready out).
REQ-035 A shared package bsg_zynq_pair_adder_pkg SHALL hold the default widths and the counter-index constants used to map the counters onto pl-to-ps CSRs.
REQ-036 The estimated implementation size is about 150-250 lines; there is no explicit FSM beyond the full flags.

Verification
REQ-037 Reset, then A=5 and B=7 presented together, ready_i=1 -> data_o=12 with v_o=1 two cycles after the yumis; sum_count_o=1, ovf_count_o=0.
REQ-038 A=0xFFFFFFFF, B=0x2 -> data_o=0x1 and ovf_count_o=1.
REQ-039 A supplies 3 words with B idle, then B supplies 3 words -> only one A yumi before B arrives; sums emerge in order.
REQ-040 ready_i=0 with 4 pairs offered -> 2 buffered plus 1 held per side, no further yumis; releasing ready_i -> 4 sums emerge in order, none lost.
REQ-041 clear_i pulsed in the same cycle as a fire, with sum_count_o=9 -> sum_count_o=0 on the next cycle.
REQ-042 aresetn dropped with 2 sums buffered -> v_o=0 immediately and both counters 0; a normal sum after release is correct.

Source files
------------

// File: rtl/bsg_zynq_pair_adder_pkg.sv
// Shared widths and CSR index map for the Zynq pair adder.
// The counter indices place the status counters onto pl-to-ps CSR slots.
package bsg_zynq_pair_adder_pkg;

    localparam int unsigned width_default_lp       = 32;
    localparam int unsigned count_width_default_lp = 32;

    typedef enum logic [0:0] {
        csr_sum_count_e = 1'b0,
        csr_ovf_count_e = 1'b1
    } csr_idx_e;

    localparam int unsigned num_csrs_lp = 2;

endpackage

// File: rtl/bsg_zynq_pair_adder_if.sv
// Operand/result handshake bundle between the Zynq FIFOs and the pair adder.
// Signal names keep the adder's own port naming so the slave view reads like its port list.
interface bsg_zynq_pair_adder_if
    import bsg_zynq_pair_adder_pkg::*;
#(
    parameter int width_p = width_default_lp
);

    logic [width_p-1:0] a_data_i;
    logic               a_v_i;
    logic               a_yumi_o;

    logic [width_p-1:0] b_data_i;
    logic               b_v_i;
    logic               b_yumi_o;

    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               ready_i;

    modport slave (
        input  a_data_i, a_v_i,
        output a_yumi_o,
        input  b_data_i, b_v_i,
        output b_yumi_o,
        output data_o, v_o,
        input  ready_i
    );

    modport master (
        output a_data_i, a_v_i,
        input  a_yumi_o,
        output b_data_i, b_v_i,
        input  b_yumi_o,
        input  data_o, v_o,
        output ready_i
    );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/ready on both sides; ready_o and v_o depend only on
// registered occupancy, so nothing on the output side reaches ready_o combinationally.
module bsg_two_fifo
    import bsg_zynq_pair_adder_pkg::*;
#(
    parameter int width_p = width_default_lp
) (
    input  logic               aclk,
    input  logic               aresetn,

    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,

    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               enq, deq;

    assign ready_o = (count_q != 2'd2);
    assign v_o     = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    assign enq = v_i & ready_o;
    assign deq = v_o & ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = ~wr_ptr_q;
        if (deq) rd_ptr_d = ~rd_ptr_q;
        if (enq && !deq)      count_d = count_q + 2'd1;
        else if (!enq && deq) count_d = count_q - 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only observed once occupancy says it was written.
    always_ff @(posedge aclk) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_zynq_pair_adder.sv
// Adds one operand from each of two ps-to-pl FIFOs and queues the sum for a pl-to-ps FIFO,
// counting sums produced and sums that carried out.
module bsg_zynq_pair_adder
    import bsg_zynq_pair_adder_pkg::*;
#(
    parameter int width_p       = width_default_lp,
    parameter int count_width_p = count_width_default_lp
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     en_i,
    input  logic                     clear_i,
    bsg_zynq_pair_adder_if.slave     io,
    output logic [count_width_p-1:0] sum_count_o,
    output logic [count_width_p-1:0] ovf_count_o
);

    logic [width_p-1:0]       a_reg_q, b_reg_q;
    logic                     a_full_q, a_full_d;
    logic                     b_full_q, b_full_d;
    logic [count_width_p-1:0] sum_count_q, sum_count_d;
    logic [count_width_p-1:0] ovf_count_q, ovf_count_d;
    logic [width_p:0]         sum_w;
    logic                     buf_ready;
    logic                     fire;
    logic                     a_yumi, b_yumi;

    assign fire  = a_full_q & b_full_q & buf_ready;
    assign sum_w = {1'b0, a_reg_q} + {1'b0, b_reg_q};

    // Gating with aresetn keeps the dequeues quiet while reset is held, even with valid inputs.
    assign a_yumi = aresetn & en_i & io.a_v_i & (~a_full_q | fire);
    assign b_yumi = aresetn & en_i & io.b_v_i & (~b_full_q | fire);

    assign io.a_yumi_o = a_yumi;
    assign io.b_yumi_o = b_yumi;

    always_comb begin
        a_full_d    = a_full_q;
        b_full_d    = b_full_q;
        sum_count_d = sum_count_q;
        ovf_count_d = ovf_count_q;

        if (a_yumi)    a_full_d = 1'b1;
        else if (fire) a_full_d = 1'b0;

        if (b_yumi)    b_full_d = 1'b1;
        else if (fire) b_full_d = 1'b0;

        // Clear takes priority over a coincident fire.
        if (clear_i) begin
            sum_count_d = '0;
            ovf_count_d = '0;
        end else if (fire) begin
            sum_count_d = sum_count_q + count_width_p'(1);
            if (sum_w[width_p]) ovf_count_d = ovf_count_q + count_width_p'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_full_q    <= 1'b0;
            b_full_q    <= 1'b0;
            sum_count_q <= '0;
            ovf_count_q <= '0;
        end else begin
            a_full_q    <= a_full_d;
            b_full_q    <= b_full_d;
            sum_count_q <= sum_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (a_yumi) a_reg_q <= io.a_data_i;
        if (b_yumi) b_reg_q <= io.b_data_i;
    end

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_out_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .v_i     (fire),
        .data_i  (sum_w[width_p-1:0]),
        .ready_o (buf_ready),
        .v_o     (io.v_o),
        .data_o  (io.data_o),
        .ready_i (io.ready_i)
    );

    assign sum_count_o = sum_count_q;
    assign ovf_count_o = ovf_count_q;

endmodule
